jk_flip_flop: RTL and testbench

- Bank of WIDTH independent, positive-edge-triggered JK flip-flops with true and complemented outputs.
- Used as a generic storage/toggle primitive: small counters, control latches, set/reset flags.
- Single clock domain; asynchronous active-low reset forces every bit to a known value.

---
 rtl/jk_ff_pkg.sv | 32 +++
 rtl/jk_flip_flop_if.sv | 41 ++++
 rtl/jk_ff_cell.sv | 60 ++++++
 rtl/jk_flip_flop.sv | 46 ++++
 tb/tb_jk_flip_flop.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/jk_ff_pkg.sv
// ---------------------------------------------------------------------------
// jk_ff_pkg
//   Shared types and helpers for the JK flip-flop bank.
//   - jk_op_e : the four JK operations, encoded as {j,k}.
//   - jk_next : next-state bit for one JK flop given the operation and the
//               current state bit.
//   - JK_MAX_WIDTH : upper bound on the number of bits in one bank.
// ---------------------------------------------------------------------------
package jk_ff_pkg;

    localparam int unsigned JK_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    function automatic logic jk_next(input jk_op_e op, input logic q);
        logic nxt;
        case (op)
            JK_HOLD:   nxt = q;
            JK_RESET:  nxt = 1'b0;
            JK_SET:    nxt = 1'b1;
            JK_TOGGLE: nxt = ~q;
            default:   nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_flip_flop_if.sv
// ---------------------------------------------------------------------------
// jk_flip_flop_if
//   Signal bundle for a bank of WIDTH JK flip-flops.
//   j, k   : per-bit J (set) / K (reset) controls, driven by the master
//   q, qn  : registered state and its complement, driven by the bank (slave)
//   ce     : per-bit clock enable       (only with JK_FF_SYNC_CTRL_EN)
//   sclr   : synchronous clear, all bits (only with JK_FF_SYNC_CTRL_EN)
//   Optional macro: JK_FF_SYNC_CTRL_EN adds ce and sclr.
// ---------------------------------------------------------------------------
interface jk_flip_flop_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
`ifdef JK_FF_SYNC_CTRL_EN
    logic [WIDTH-1:0] ce;
    logic             sclr;

    modport master (
        output j, k, ce, sclr,
        input  q, qn
    );

    modport slave (
        input  j, k, ce, sclr,
        output q, qn
    );
`else
    modport master (
        output j, k,
        input  q, qn
    );

    modport slave (
        input  j, k,
        output q, qn
    );
`endif
endinterface

// File: rtl/jk_ff_cell.sv
// ---------------------------------------------------------------------------
// jk_ff_cell
//   One positive-edge JK flip-flop with asynchronous active-low reset.
//   Ports:
//     clk   in   clock, state updates on rising edge
//     rst   in   asynchronous active-low reset, loads RST_BIT
//     j, k  in   JK controls, sampled on rising clk while rst=1
//     ce    in   clock enable, 0 holds state   (JK_FF_SYNC_CTRL_EN only)
//     sclr  in   synchronous clear to 0        (JK_FF_SYNC_CTRL_EN only)
//     q     out  registered state
//     qn    out  complement of q
//   Priority: rst > sclr > ce > j/k.
//   Optional macro: JK_FF_SYNC_CTRL_EN.
// ---------------------------------------------------------------------------
module jk_ff_cell
    import jk_ff_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
`ifdef JK_FF_SYNC_CTRL_EN
    input  logic ce,
    input  logic sclr,
`endif
    output logic q,
    output logic qn
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = jk_next(jk_op_e'({j, k}), state_q);
`ifdef JK_FF_SYNC_CTRL_EN
        // Later assignments win, giving sclr priority over ce over j/k.
        if (!ce) begin
            state_d = state_q;
        end
        if (sclr) begin
            state_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST_BIT;
        end else begin
            state_q <= state_d;
        end
    end

    // qn comes from the same register, so q and qn can never agree.
    assign q  = state_q;
    assign qn = ~state_q;

endmodule

// File: rtl/jk_flip_flop.sv
// ---------------------------------------------------------------------------
// jk_flip_flop
//   Bank of WIDTH independent positive-edge JK flip-flops.
//   Ports:
//     clk   in     clock
//     rst   in     asynchronous active-low reset, loads RST_VAL into q
//     bus   slave  jk_flip_flop_if: j, k in; q, qn out
//                  (+ ce, sclr in when JK_FF_SYNC_CTRL_EN is defined)
//   Parameters:
//     WIDTH   number of bits, 1..64
//     RST_VAL reset value of q
//   Optional macro: JK_FF_SYNC_CTRL_EN.
// ---------------------------------------------------------------------------
module jk_flip_flop #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    jk_flip_flop_if.slave  bus
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .j    (bus.j[i]),
            .k    (bus.k[i]),
`ifdef JK_FF_SYNC_CTRL_EN
            .ce   (bus.ce[i]),
            .sclr (bus.sclr),
`endif
            .q    (q_w[i]),
            .qn   (qn_w[i])
        );
    end

    assign bus.q  = q_w;
    assign bus.qn = qn_w;

endmodule

// File: tb/tb_jk_flip_flop.sv
// ---------------------------------------------------------------------------
// tb_jk_flip_flop
//   Two banks share clk and rst: a 1-bit bank with reset value 0 and a
//   4-bit bank with reset value 4'b1010. Expected state comes from the JK
//   characteristic equation q+ = j&~q | ~k&q applied to whole vectors.
// ---------------------------------------------------------------------------
module tb_jk_flip_flop;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       j1, k1, ce1;
    logic [3:0] j4, k4, ce4;
    logic       sclr;

    logic       m1;
    logic [3:0] m4;

    int n_assert = 0;
    int n_fail   = 0;

    jk_flip_flop_if #(.WIDTH(1)) bus1 ();
    jk_flip_flop_if #(.WIDTH(4)) bus4 ();

    assign bus1.j = j1;
    assign bus1.k = k1;
    assign bus4.j = j4;
    assign bus4.k = k4;
`ifdef JK_FF_SYNC_CTRL_EN
    assign bus1.ce   = ce1;
    assign bus4.ce   = ce4;
    assign bus1.sclr = sclr;
    assign bus4.sclr = sclr;
`endif

    jk_flip_flop #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    jk_flip_flop #(.WIDTH(4), .RST_VAL(4'b1010)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    function automatic logic [3:0] ref_next(input logic [3:0] q, input logic [3:0] j,
                                            input logic [3:0] k, input logic [3:0] ce,
                                            input logic clr);
        logic [3:0] jk;
        jk = (j & ~q) | (~k & q);
        if (clr) return 4'b0000;
        return (jk & ce) | (q & ~ce);
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q1"},  {3'b000, bus1.q},  {3'b000, m1});
        chk({tag, "_qn1"}, {3'b000, bus1.qn}, {3'b000, ~m1});
        chk({tag, "_q4"},  bus4.q,  m4);
        chk({tag, "_qn4"}, bus4.qn, ~m4);
    endtask

    // Wait for the next rising edge, advance the model, and check just after.
    task automatic cycle(input string tag);
        logic [3:0] t;
        @(posedge clk);
        #1;
        if (rst) begin
            t  = ref_next({3'b000, m1}, {3'b000, j1}, {3'b000, k1}, {3'b000, ce1}, sclr);
            m1 = t[0];
            m4 = ref_next(m4, j4, k4, ce4, sclr);
        end
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b0;
        m1  = 1'b0;
        m4  = 4'b1010;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [1:0] ops [8];
        logic       exp_seq [8];
        ops     = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        ce1 = 1'b1; ce4 = 4'b1111; sclr = 1'b0;
        j1 = 1'bx; k1 = 1'bx; j4 = 4'bxxxx; k4 = 4'bxxxx;
        m1 = 1'b0; m4 = 4'b1010;

        // Reset with undriven j/k, held across a clock edge.
        rst = 1'b1;
        #1;
        async_reset("rst_async");
        cycle("rst_hold");
        #4;
        rst = 1'b1;
        j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
        cycle("release");

        // Directed op sequence on the 1-bit bank, checked against fixed values.
        for (int i = 0; i < 8; i++) begin
            {j1, k1} = ops[i];
            cycle("seq");
            chk("seq_fixed", {3'b000, bus1.q}, {3'b000, exp_seq[i]});
        end

        // Held toggle from q=0.
        j1 = 1'b1; k1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("toggle");
            chk("toggle_fixed", {3'b000, bus1.q}, {3'b000, (i % 2 == 0) ? 1'b1 : 1'b0});
        end

        // 4-bit bank: set/reset mix, then toggle all.
        j1 = 1'b0; k1 = 1'b0;
        j4 = 4'b0101; k4 = 4'b1010;
        cycle("w4_setrst");
        chk("w4_setrst_fixed", bus4.q, 4'b0101);
        j4 = 4'b1111; k4 = 4'b1111;
        cycle("w4_toggle");
        chk("w4_toggle_fixed", bus4.q, 4'b1010);

        // Async reset 2 ns after an edge, then set on the next edge.
        j1 = 1'b1; k1 = 1'b0; j4 = 4'b0101; k4 = 4'b0000;
        cycle("pre_rst_set");
        #1;
        j1 = 1'b1; k1 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;
        async_reset("mid_rst");
        chk("mid_rst_fixed", {3'b000, bus1.q}, 4'b0000);
        rst = 1'b1;
        j1 = 1'b1; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
        cycle("post_rst_set");
        chk("post_rst_set_fixed", {3'b000, bus1.q}, 4'b0001);

`ifdef JK_FF_SYNC_CTRL_EN
        // Clock enable low holds, synchronous clear overrides everything.
        j1 = 1'b0; k1 = 1'b1; ce1 = 1'b0;
        j4 = 4'b1111; k4 = 4'b0000; ce4 = 4'b0011;
        cycle("ce_hold");
        chk("ce_hold_fixed", {3'b000, bus1.q}, 4'b0001);
        chk("ce_part_fixed", bus4.q, 4'b1010 | 4'b0011);
        j1 = 1'b1; k1 = 1'b0; ce1 = 1'b1; ce4 = 4'b0000; sclr = 1'b1;
        cycle("sclr");
        chk("sclr_fixed", bus4.q, 4'b0000);
        sclr = 1'b0; ce1 = 1'b1; ce4 = 4'b1111;
`endif

        // Randomized operation with occasional mid-cycle resets.
        for (int i = 0; i < 300; i++) begin
            j1 = 1'($urandom); k1 = 1'($urandom);
            j4 = 4'($urandom); k4 = 4'($urandom);
`ifdef JK_FF_SYNC_CTRL_EN
            ce1  = 1'($urandom);
            ce4  = 4'($urandom);
            sclr = ($urandom_range(0, 7) == 0);
`endif
            cycle("rand");
            if ($urandom_range(0, 15) == 0) begin
                #1;
                async_reset("rand_rst");
                rst = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
